// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out transmitter
//
// A word is taken on an in_valid/in_ready handshake. It is then sent one bit
// per cycle on sd, with sen marking every cycle that carries a valid bit. The
// serial pair is meant to drive a downstream SIPO (sd -> D, sen -> shift
// enable). done pulses for one cycle when the block returns to idle.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1 = send in_data[WIDTH-1] first, 0 = send in_data[0] first
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-low
//   in_valid  in   parallel word offered
//   in_data   in   parallel word (WIDTH bits)
//   in_ready  out  block is idle and accepts a word this cycle
//   stall     in   freeze shifting while high
//   sd        out  serial data
//   sen       out  serial shift enable, high only with a valid bit on sd
//   busy      out  word in flight (complement of in_ready)
//   done      out  one-cycle pulse after the final bit of a word
//
// Optional feature
//   PISO_PARITY_EN  when defined, an even-parity bit follows the data bits
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  output logic             sd,
  output logic             sen,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sd_q, sd_d;
  logic             sen_q, sen_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit that goes out next from a word held in the shift register.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word after removing the head bit; vacated positions fill with zero so the
  // register is empty once the frame has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // cnt_q is the index (counting down) of the bit currently shown on sd.
  // The first bit is placed on sd by the load edge itself, so a SHIFT edge
  // with cnt_q == 0 means the last data bit has already been on the line for
  // one cycle and the frame can close (or move on to the parity bit).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sd_d    = sd_q;
    sen_d   = 1'b0;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sd_d    = head(in_data);
          sen_d   = 1'b1;
          sh_d    = advance(in_data);
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SHIFT;
          ready_d = 1'b0;
`ifdef PISO_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      S_SHIFT: begin
        if (!stall) begin
          if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
            sd_d    = par_q;
            sen_d   = 1'b1;
`else
            state_d = S_IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
`endif
          end else begin
            sd_d  = head(sh_q);
            sh_d  = advance(sh_q);
            cnt_d = cnt_q - CW'(1);
            sen_d = 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (!stall) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
    busy_d = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sd_q    <= 1'b0;
      sen_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      sd_q    <= sd_d;
      sen_q   <= sen_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign sd       = sd_q;
  assign sen      = sen_q;
  assign done     = done_q;

endmodule
